keypad_matrix_emulator: RTL
===========================

KEYPAD_MATRIX_EMULATOR -- requirements
Module: keypad_matrix_emulator

Interface
REQ-001 Parameter: BOUNCE_CYCLES, default 8, number of cycles of contact bounce at press and at release (legal range 1..255).
REQ-002 Parameter: HOLD_W, default 16, width of the hold-duration field.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 cmd_valid  input  1  press command offered.
REQ-006 cmd_ready  output  1  emulator can accept a command.
REQ-007 cmd_code  input  4  key index, key = 4*row_index + col_index.
REQ-008 cmd_hold  input  HOLD_W  stable-pressed duration in cycles.
REQ-009 row  input  4  scan drive from the keypad scanner, active-high, one-hot or zero.
REQ-010 col  output  4  sensed column lines returned to the scanner, active-high.
REQ-011 key_state  output  16  current contact state per key; bit j is key j.
REQ-012 busy  output  1  command in progress.
REQ-013 done  output  1  one-cycle pulse at command completion.

Function
REQ-014 col[c] SHALL equal the OR over r of (row[r] AND key_state[4r+c]); this is a combinational path with zero latency, and with row==0, col==0.
REQ-015 The FSM SHALL have the states IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT and SHALL hold at most one key active at any time.
REQ-016 cmd_ready SHALL be 1 only in IDLE, and busy SHALL equal NOT cmd_ready.
REQ-017 A command SHALL be accepted on the edge where cmd_valid AND cmd_ready; code and hold are latched on that edge, and the FSM enters BOUNCE_IN.
REQ-018 BOUNCE_IN SHALL last exactly BOUNCE_CYCLES cycles: active key contact = lfsr[0] in all cycles except the last, and 1 in the last.
REQ-019 HOLD SHALL last exactly max(cmd_hold,1) cycles with contact 1; cmd_hold==0 is treated as 1.
REQ-020 BOUNCE_OUT SHALL last exactly BOUNCE_CYCLES cycles: contact = lfsr[0] except in the last cycle, where it is 0; the FSM then returns to IDLE.
REQ-021 done SHALL be 1 for the single cycle in which the FSM transitions from BOUNCE_OUT to IDLE.
REQ-022 In IDLE, key_state SHALL be 0; outside IDLE, only bit cmd_code latched may be 1.
REQ-023 LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, seed 8'hA5, advancing every cycle regardless of state.
REQ-024 A cmd_valid asserted while busy SHALL be ignored, with no queueing, and the command inputs SHALL NOT be re-sampled.
REQ-025 A back-to-back command offered in the done cycle SHALL be accepted on the next edge, since cmd_ready is already 1 in that cycle.
REQ-026 The hold counter SHALL count down from the latched value; no wrap-around is permitted, and HOLD exits when the count reaches 1.

Reset
REQ-027 On a clock edge with rst==0: state=IDLE, key_state=0, done=0, busy=0, cmd_ready=1 (from the next cycle), lfsr=8'hA5, and counters and latched code are cleared.
REQ-028 A reset in mid-command SHALL abort the command immediately with no done pulse; col goes to 0 in the cycle after the reset edge.

Structure
REQ-029 A shared package keypad_pkg SHALL hold the state enum, NUM_KEYS=16, NUM_ROWS=NUM_COLS=4, LFSR_SEED=8'hA5, and the LFSR tap mask, all reused by the scanner-side logic.
REQ-030 The LFSR SHALL be a sub-module kp_lfsr (clk, rst, q[7:0]); the FSM, counters and column mux live in the top module.

Verification
REQ-031 Reset: hold rst=0 for 2 cycles with cmd_valid=1 -> cmd_ready=1, key_state=0, col=0, and no command accepted until the first edge with rst=1.
REQ-032 Single press: code=4'd6, hold=20, BOUNCE_CYCLES=8, row=4'b0010 held -> busy for exactly 8+20+8=36 cycles, col=4'b0100 stable for all 20 HOLD cycles, done pulse once, then col=0.
REQ-033 Row selectivity: during HOLD of code 6, drive row=4'b0001, 4'b0100 and 4'b1000 -> col=0 each time; row=4'b0010 -> col=4'b0100.
REQ-034 Busy rejection: issue code 3 and then, 5 cycles later, code 12 -> only key_state[3] ever asserts, and a single done pulse is seen.
REQ-035 Edge values: code=15, hold=0 -> HOLD lasts 1 cycle, total busy 17 cycles; with row=4'b1000, col[3]=1 during HOLD.
REQ-036 Mid-command reset: code 9, hold 50, with rst=0 asserted in cycle 15 -> key_state=0, no done pulse, and a new command is accepted on the first edge with rst=1.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: matrix geometry, emulator FSM states and the
// scramble LFSR used to model contact bounce.
package keypad_pkg;

   localparam int NUM_KEYS = 16;
   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   // x^8 + x^6 + x^5 + x^4 + 1 on a left-shifting register: bits 7,5,4,3
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   typedef enum logic [1:0] {
      IDLE,
      BOUNCE_IN,
      HOLD,
      BOUNCE_OUT
   } kp_state_t;

   function automatic logic [7:0] lfsr_next(input logic [7:0] q);
      return {q[6:0], ^(q & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/kp_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; supplies the pseudo-random bounce pattern.
module kp_lfsr
   import keypad_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] q
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         q <= LFSR_SEED;
      end else begin
         q <= lfsr_next(q);
      end
   end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Emulates one key of a 4x4 matrix keypad at a time: press bounce, stable hold,
// release bounce, with the column lines answering the scanner's row drive.
module keypad_matrix_emulator
   import keypad_pkg::*;
#(
   parameter int BOUNCE_CYCLES = 8,
   parameter int HOLD_W        = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [3:0]          cmd_code,
   input  logic [HOLD_W-1:0]   cmd_hold,
   input  logic [3:0]          row,
   output logic [3:0]          col,
   output logic [NUM_KEYS-1:0] key_state,
   output logic                busy,
   output logic                done
);

   localparam int CNT_W = (HOLD_W > 8) ? HOLD_W : 8;
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES);

   kp_state_t         state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [CNT_W-1:0]  hold_load;
   logic [3:0]        code_q;
   logic [HOLD_W-1:0] hold_q;
   logic              done_n;
   logic              accept;
   logic              contact;
   logic [7:0]        lfsr;
   logic              unused_lfsr;

   kp_lfsr u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (lfsr)
   );

   assign unused_lfsr = ^lfsr[7:1];
   assign cmd_ready   = (state == IDLE);
   assign busy        = ~cmd_ready;
   // A zero hold still yields one stable cycle.
   assign hold_load   = (hold_q == '0) ? CNT_ONE : CNT_W'(hold_q);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      done_n  = 1'b0;
      accept  = 1'b0;
      contact = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               accept  = 1'b1;
               state_n = BOUNCE_IN;
               cnt_n   = BOUNCE_LOAD;
            end
         end
         BOUNCE_IN: begin
            contact = (cnt == CNT_ONE) ? 1'b1 : lfsr[0];
            if (cnt == CNT_ONE) begin
               state_n = HOLD;
               cnt_n   = hold_load;
            end else begin
               cnt_n = cnt - CNT_ONE;
            end
         end
         HOLD: begin
            contact = 1'b1;
            if (cnt == CNT_ONE) begin
               state_n = BOUNCE_OUT;
               cnt_n   = BOUNCE_LOAD;
            end else begin
               cnt_n = cnt - CNT_ONE;
            end
         end
         BOUNCE_OUT: begin
            contact = (cnt != CNT_ONE) & lfsr[0];
            if (cnt == CNT_ONE) begin
               state_n = IDLE;
               cnt_n   = '0;
               done_n  = 1'b1;
            end else begin
               cnt_n = cnt - CNT_ONE;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         code_q <= '0;
         hold_q <= '0;
         done   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         done  <= done_n;
         if (accept) begin
            code_q <= cmd_code;
            hold_q <= cmd_hold;
         end
      end
   end

   always_comb begin
      key_state         = '0;
      key_state[code_q] = contact;
   end

   // Scanner sees a column high when any driven row crosses a closed contact.
   always_comb begin
      col = '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
         for (int c = 0; c < NUM_COLS; c++) begin
            col[c] = col[c] | (row[r] & key_state[NUM_COLS*r + c]);
         end
      end
   end

endmodule
